// File: rtl/motor_ctrl_pkg.sv
// Shared types, widths and the saturating clamp used by the wheel speed loop.
package motor_ctrl_pkg;

  localparam int SPEED_W = 7;
  localparam int DUTY_W  = 8;
  localparam int INTEG_W = 16;
  localparam int ERR_W   = SPEED_W + 1;
  localparam int U_W     = 18;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ERR   = 2'd1,
    ST_INTEG = 2'd2,
    ST_OUT   = 2'd3
  } pi_state_e;

  function automatic logic signed [31:0] clamp_s32(
    input logic signed [31:0] v,
    input logic signed [31:0] lo,
    input logic signed [31:0] hi
  );
    if (v < lo)      return lo;
    else if (v > hi) return hi;
    else             return v;
  endfunction

endpackage

// File: rtl/pwm_gen.sv
// 8-bit PWM with prescaler; duty is shadowed and only taken at counter wrap
// so a period in progress always completes with its original duty.
module pwm_gen
  import motor_ctrl_pkg::*;
#(
  parameter int PWM_DIV = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              enable,
  input  logic [DUTY_W-1:0] duty,
  output logic              pwm_out
);

  localparam int DIV_W = (PWM_DIV > 1) ? $clog2(PWM_DIV) : 1;

  logic [DIV_W-1:0]  div_q,      div_d;
  logic [DUTY_W-1:0] cnt_q,      cnt_d;
  logic [DUTY_W-1:0] duty_act_q, duty_act_d;
  logic              tick;
  logic              wrap;

  assign tick = (div_q == DIV_W'(PWM_DIV - 1));
  assign wrap = tick && (cnt_q == {DUTY_W{1'b1}});

  always_comb begin
    div_d      = tick ? '0 : div_q + DIV_W'(1);
    cnt_d      = tick ? cnt_q + DUTY_W'(1) : cnt_q;
    duty_act_d = wrap ? duty : duty_act_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      div_q      <= '0;
      cnt_q      <= '0;
      duty_act_q <= '0;
    end else begin
      div_q      <= div_d;
      cnt_q      <= cnt_d;
      duty_act_q <= duty_act_d;
    end
  end

  // Gated with enable directly so the drive drops in the same cycle.
  assign pwm_out = enable & (cnt_q < duty_act_q);

endmodule

// File: rtl/speed_pi_ctrl.sv
// PI speed loop: one update per encoder window (ERR -> INTEG -> OUT), with
// integrator clamping, anti-windup on output saturation, and PWM drive.
module speed_pi_ctrl
  import motor_ctrl_pkg::*;
#(
  parameter int KP        = 4,
  parameter int KI        = 1,
  parameter int OUT_SHIFT = 2,
  parameter int INT_MAX   = 4095,
  parameter int PWM_DIV   = 1
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [SPEED_W-1:0] setpoint,
  input  logic [SPEED_W-1:0] enc,
  input  logic               enc_strobe,
  output logic [DUTY_W-1:0]  duty,
  output logic               pwm_out,
  output logic               sat_hi,
  output logic               sat_lo,
  output logic               upd
);

  localparam logic signed [U_W-1:0] DUTY_MAX_U = U_W'((1 << DUTY_W) - 1);

  pi_state_e                  state_q,  state_d;
  logic                       strobe_q;
  logic signed [ERR_W-1:0]    err_q,    err_d;
  logic signed [INTEG_W-1:0]  integ_q,  integ_d;
  logic [DUTY_W-1:0]          duty_q,   duty_d;
  logic                       sat_hi_q, sat_hi_d;
  logic                       sat_lo_q, sat_lo_d;
  logic                       upd_q,    upd_d;

  logic                       strobe_edge;
  logic                       err_pos;
  logic                       err_neg;
  logic                       hold_integ;
  logic signed [31:0]         err_ext;
  logic signed [31:0]         integ_ext;
  logic signed [31:0]         integ_sum;
  logic signed [U_W-1:0]      u_s;
  logic signed [U_W-1:0]      u_sh;

  assign strobe_edge = enc_strobe & ~strobe_q & (state_q == ST_IDLE);

  assign err_pos    = ~err_q[ERR_W-1] & (err_q != '0);
  assign err_neg    = err_q[ERR_W-1];
  // Stop integrating further into a saturated output; unwinding is allowed.
  assign hold_integ = (sat_hi_q & err_pos) | (sat_lo_q & err_neg);

  assign err_ext   = 32'(err_q);
  assign integ_ext = 32'(integ_q);
  assign integ_sum = integ_ext + KI * err_ext;
  assign u_s       = U_W'(KP * err_ext + integ_ext);
  assign u_sh      = u_s >>> OUT_SHIFT;

  always_comb begin
    state_d  = state_q;
    err_d    = err_q;
    integ_d  = integ_q;
    duty_d   = duty_q;
    sat_hi_d = sat_hi_q;
    sat_lo_d = sat_lo_q;
    upd_d    = 1'b0;

    if (!enable) begin
      state_d  = ST_IDLE;
      err_d    = '0;
      integ_d  = '0;
      duty_d   = '0;
      sat_hi_d = 1'b0;
      sat_lo_d = 1'b0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (strobe_edge) state_d = ST_ERR;
        end
        ST_ERR: begin
          err_d   = $signed({1'b0, setpoint}) - $signed({1'b0, enc});
          state_d = ST_INTEG;
        end
        ST_INTEG: begin
          if (!hold_integ) begin
            integ_d = INTEG_W'(clamp_s32(integ_sum, -INT_MAX, INT_MAX));
          end
          state_d = ST_OUT;
        end
        ST_OUT: begin
          duty_d   = DUTY_W'(clamp_s32(32'(u_sh), 0, (1 << DUTY_W) - 1));
          sat_hi_d = (u_sh > DUTY_MAX_U);
          sat_lo_d = u_sh[U_W-1];
          upd_d    = 1'b1;
          state_d  = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      strobe_q <= 1'b0;
      err_q    <= '0;
      integ_q  <= '0;
      duty_q   <= '0;
      sat_hi_q <= 1'b0;
      sat_lo_q <= 1'b0;
      upd_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      strobe_q <= enc_strobe;
      err_q    <= err_d;
      integ_q  <= integ_d;
      duty_q   <= duty_d;
      sat_hi_q <= sat_hi_d;
      sat_lo_q <= sat_lo_d;
      upd_q    <= upd_d;
    end
  end

  pwm_gen #(
    .PWM_DIV (PWM_DIV)
  ) u_pwm (
    .clk     (clk),
    .reset   (reset),
    .enable  (enable),
    .duty    (duty_q),
    .pwm_out (pwm_out)
  );

  assign duty   = duty_q;
  assign sat_hi = sat_hi_q;
  assign sat_lo = sat_lo_q;
  assign upd    = upd_q;

endmodule

// File: tb/tb_speed_pi_ctrl.sv
// Scoreboard bench for speed_pi_ctrl: expected updates are queued when a
// strobe is driven and compared when upd fires.
module tb_speed_pi_ctrl;

  logic       clk;
  logic       reset;
  logic       enable;
  logic [6:0] setpoint;
  logic [6:0] enc;
  logic       enc_strobe;
  logic [7:0] duty;
  logic       pwm_out;
  logic       sat_hi;
  logic       sat_lo;
  logic       upd;

  typedef struct {
    int duty;
    int hi;
    int lo;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_err    = 0;
  int   m_integ  = 0;
  int   m_hi     = 0;
  int   m_lo     = 0;

  speed_pi_ctrl #(
    .KP(4), .KI(1), .OUT_SHIFT(2), .INT_MAX(4095), .PWM_DIV(1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .setpoint   (setpoint),
    .enc        (enc),
    .enc_strobe (enc_strobe),
    .duty       (duty),
    .pwm_out    (pwm_out),
    .sat_hi     (sat_hi),
    .sat_lo     (sat_lo),
    .upd        (upd)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference PI step: err, anti-windup, integrator clamp, shift, output clamp.
  function automatic exp_t predict(input int sp, input int e);
    exp_t r;
    int err, u, s;
    err = sp - e;
    if (!((m_hi != 0 && err > 0) || (m_lo != 0 && err < 0))) begin
      m_integ = m_integ + 1 * err;
      if (m_integ > 4095)  m_integ = 4095;
      if (m_integ < -4095) m_integ = -4095;
    end
    u = 4 * err + m_integ;
    s = u >>> 2;
    r.duty = (s > 255) ? 255 : (s < 0) ? 0 : s;
    r.hi   = (s > 255) ? 1 : 0;
    r.lo   = (s < 0) ? 1 : 0;
    m_hi   = r.hi;
    m_lo   = r.lo;
    return r;
  endfunction

  always @(negedge clk) begin
    if (upd === 1'b1) begin
      $display("upd: duty=%0d sat_hi=%0d sat_lo=%0d", duty, sat_hi, sat_lo);
      if (sb.size() == 0) begin
        check("spurious_upd", 1, 0);
      end else begin
        exp_t x;
        x = sb.pop_front();
        check("sb_duty", int'(duty), x.duty);
        check("sb_sat_hi", int'(sat_hi), x.hi);
        check("sb_sat_lo", int'(sat_lo), x.lo);
      end
    end
  end

  task automatic model_clear();
    m_integ = 0;
    m_hi    = 0;
    m_lo    = 0;
  endtask

  task automatic apply_reset();
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    sb.delete();
    model_clear();
  endtask

  task automatic do_strobe(input logic [6:0] sp, input logic [6:0] e);
    int lat;
    lat = 0;
    @(negedge clk);
    setpoint   = sp;
    enc        = e;
    enc_strobe = 1'b1;
    sb.push_back(predict(int'(sp), int'(e)));
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 1) enc_strobe = 1'b0;
      if (upd === 1'b1) begin
        lat = i;
        break;
      end
    end
    check("upd_latency", lat, 4);
    @(negedge clk);
    check("upd_width", int'(upd), 0);
  endtask

  task automatic wait_pwm_rise(output bit ok);
    logic prev;
    ok   = 1'b0;
    prev = pwm_out;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (prev === 1'b0 && pwm_out === 1'b1) begin
        ok = 1'b1;
        break;
      end
      prev = pwm_out;
    end
    if (!ok) check("pwm_rise_timeout", 0, 1);
  endtask

  initial begin
    bit ok;
    int hi_cnt[3];

    reset      = 1'b1;
    enable     = 1'b1;
    setpoint   = '0;
    enc        = '0;
    enc_strobe = 1'b0;
    #3 reset = 1'b0;
    #1;
    check("rst_duty", int'(duty), 0);
    check("rst_pwm", int'(pwm_out), 0);
    check("rst_sat_hi", int'(sat_hi), 0);
    check("rst_sat_lo", int'(sat_lo), 0);
    check("rst_upd", int'(upd), 0);
    repeat (2) @(negedge clk);
    reset = 1'b1;

    // First update from a cleared integrator.
    do_strobe(7'd64, 7'd0);
    check("t1_duty80", int'(duty), 80);
    check("t1_nosat", int'(sat_hi | sat_lo), 0);

    // Drive into high saturation, then show the integrator stopped at 635.
    apply_reset();
    for (int k = 0; k < 6; k++) do_strobe(7'd127, 7'd0);
    check("t2_duty255", int'(duty), 255);
    check("t2_sat_hi", int'(sat_hi), 1);
    do_strobe(7'd0, 7'd0);
    check("t2_antiwindup", int'(duty), 158);

    // Negative error saturates low.
    apply_reset();
    do_strobe(7'd0, 7'd50);
    check("t3_duty0", int'(duty), 0);
    check("t3_sat_lo", int'(sat_lo), 1);

    // Reach duty 64, then 128 mid-period.
    apply_reset();
    do_strobe(7'd127, 7'd0);
    do_strobe(7'd26, 7'd0);
    check("t4_duty64", int'(duty), 64);
    wait_pwm_rise(ok);
    hi_cnt = '{0, 0, 0};
    hi_cnt[0] = int'(pwm_out);
    for (int i = 1; i < 768; i++) begin
      if (i == 356) begin
        setpoint   = 7'd72;
        enc        = 7'd0;
        enc_strobe = 1'b1;
        sb.push_back(predict(72, 0));
      end
      if (i == 357) enc_strobe = 1'b0;
      @(negedge clk);
      hi_cnt[i / 256] += int'(pwm_out);
    end
    check("pwm_period0_high", hi_cnt[0], 64);
    check("pwm_period1_high", hi_cnt[1], 64);
    check("pwm_period2_high", hi_cnt[2], 128);
    check("t4_duty128", int'(duty), 128);

    // Enable dropped while the FSM is in INTEG.
    wait_pwm_rise(ok);
    setpoint   = 7'd64;
    enc        = 7'd0;
    enc_strobe = 1'b1;
    @(negedge clk);
    enc_strobe = 1'b0;
    @(negedge clk);
    check("t5_pwm_pre", int'(pwm_out), 1);
    enable = 1'b0;
    #1 check("t5_pwm_comb", int'(pwm_out), 0);
    @(negedge clk);
    check("t5_duty0", int'(duty), 0);
    check("t5_sat_hi0", int'(sat_hi), 0);
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t5_no_upd", int'(upd), 0);
    end
    enable = 1'b1;
    model_clear();

    // Edge coinciding with enable fall is discarded.
    @(negedge clk);
    enc_strobe = 1'b1;
    enable     = 1'b0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      check("t6_no_upd", int'(upd), 0);
    end
    enc_strobe = 1'b0;
    enable     = 1'b1;
    model_clear();
    @(negedge clk);

    // Restart after enable: integrator was cleared.
    do_strobe(7'd64, 7'd0);
    check("t7_duty80", int'(duty), 80);

    // Reset mid-sequence, then a clean first update.
    @(negedge clk);
    setpoint   = 7'd127;
    enc        = 7'd0;
    enc_strobe = 1'b1;
    @(negedge clk);
    enc_strobe = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("t8_rst_duty", int'(duty), 0);
    check("t8_rst_pwm", int'(pwm_out), 0);
    check("t8_rst_sat", int'(sat_hi | sat_lo), 0);
    check("t8_rst_upd", int'(upd), 0);
    @(negedge clk);
    reset = 1'b1;
    sb.delete();
    model_clear();
    do_strobe(7'd64, 7'd0);
    check("t8_duty80", int'(duty), 80);

    repeat (4) @(negedge clk);
    check("sb_empty", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
